escalonador: RTL and testbench
==============================

ESCALONADOR -- requirements
Module: escalonador

Interface
REQ-001 Parameter NUM_CONTEXTOS, default 8, is the number of context IDs; ID 0 is the SO, IDs 1..NUM_CONTEXTOS-1 are user contexts.
REQ-002 Parameter ID_W, default 3, is the width of a context-ID field and equals clog2(NUM_CONTEXTOS).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port ativar, input, 1 bit: single-cycle strobe that marks context ativar_id ready.
REQ-007 Port ativar_id, input, ID_W bits: context to mark ready.
REQ-008 Port encerrar, input, 1 bit: single-cycle strobe that removes context encerrar_id from the ready set.
REQ-009 Port encerrar_id, input, ID_W bits: context to remove.
REQ-010 Port pedido_troca, input, 1 bit: single-cycle strobe from the timer when a quantum expires.
REQ-011 Port prox_ack, input, 1 bit: the consumer has taken prox_contexto.
REQ-012 Port prox_contexto, output, 32 bits: chosen next context, zero-extended ID.
REQ-013 Port prox_valido, output, 1 bit: prox_contexto is valid.
REQ-014 Port prontos, output, NUM_CONTEXTOS bits: the ready bitmap.
REQ-015 Port num_trocas, output, 16 bits: count of completed handshakes.
REQ-016 Port pedido_perdido, output, 1 bit: sticky flag for a pedido_troca that was ignored.

Function
REQ-017 prontos[0] SHALL always read 0; ativar with ID 0 or ID >= NUM_CONTEXTOS SHALL be ignored.
REQ-018 ativar sets prontos[ativar_id] and encerrar clears prontos[encerrar_id] at the next edge; if both strobes target the same ID in one cycle, encerrar SHALL win.
REQ-019 The FSM states SHALL be OCIOSO, BUSCA and ENTREGA; it resets to OCIOSO.
REQ-020 OCIOSO: pedido_troca=1 SHALL move the FSM to BUSCA on the next edge.
REQ-021 BUSCA: in exactly 1 cycle, pick the first set bit of prontos, scanning round-robin from ultimo+1 and wrapping from NUM_CONTEXTOS-1 to 1. ultimo itself may be chosen only if it is the sole ready context. If no bit is set, choose 0. Latch the result and move to ENTREGA.
REQ-022 The scan SHALL use the prontos value registered at the start of the BUSCA cycle; strobes in that same cycle take effect afterwards.
REQ-023 ENTREGA: prox_valido=1 and prox_contexto holds the latched ID stable until prox_ack=1. On that edge: ultimo <= latched ID, num_trocas increments, FSM returns to OCIOSO.
REQ-024 prox_valido SHALL deassert in the cycle after the ack edge; latency from pedido_troca to prox_valido is exactly 2 cycles.
REQ-025 In ENTREGA, an encerrar hitting a latched non-zero ID (without prox_ack that cycle) SHALL drop prox_valido and return to BUSCA, which rescans.
REQ-026 num_trocas SHALL saturate at 16'hFFFF.
REQ-027 pedido_troca arriving in BUSCA or ENTREGA SHALL be ignored and SHALL set pedido_perdido, which holds until reset.
REQ-028 prox_ack outside ENTREGA SHALL have no effect.

Reset
REQ-029 While rst_n=0 (asynchronously): prontos=0, ultimo=0, FSM=OCIOSO, prox_contexto=0, prox_valido=0, num_trocas=0, pedido_perdido=0.
REQ-030 A reset in the middle of a handshake SHALL abandon it with no count; the first edge after release sees state OCIOSO.

Structure
REQ-031 Package escalonador_pkg SHALL hold NUM_CONTEXTOS, ID_W, the state encoding, and the SO ID constant (0).
REQ-032 Sub-module seletor_rr SHALL be a combinational rotating priority picker: inputs bitmap and start index; outputs chosen ID and a found flag.

Verification
REQ-033 Activate IDs 2 and 5, ultimo=0, pulse pedido_troca -> prox_valido after 2 cycles, prox_contexto=2; ack, repeat -> 5; repeat -> 2 (wrap).
REQ-034 Empty ready set, pulse pedido_troca -> prox_contexto=0, prox_valido=1; ack -> num_trocas=1.
REQ-035 ativar and encerrar both with ID 3 in the same cycle -> prontos[3]=0; ativar ID 0 -> prontos=0.
REQ-036 Only ID 4 ready, in ENTREGA with 4 latched, pulse encerrar 4 -> prox_valido drops, rescan, prox_contexto=0.
REQ-037 pedido_troca during ENTREGA -> pedido_perdido=1, no extra handshake; rst_n=0 mid-ENTREGA -> all outputs 0 immediately.
REQ-038 Force num_trocas to 16'hFFFE, complete 3 handshakes -> num_trocas stays at 16'hFFFF.

Source files
------------

// File: rtl/escalonador_pkg.sv
// Shared constants and state encoding for the round-robin context scheduler.
package escalonador_pkg;
    localparam int NUM_CONTEXTOS = 8;
    localparam int ID_W          = $clog2(NUM_CONTEXTOS);

    // ID 0 is reserved for the operating system and is the "nothing ready" answer.
    localparam logic [ID_W-1:0] SO_ID = '0;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        BUSCA   = 2'd1,
        ENTREGA = 2'd2
    } estado_t;
endpackage

// File: rtl/escalonador_seletor_rr.sv
// Combinational rotating-priority picker over user contexts 1..NUM_CTX-1,
// starting right after i_inicio; i_inicio itself is considered last.
module seletor_rr
    import escalonador_pkg::*;
#(
    parameter int NUM_CTX = escalonador_pkg::NUM_CONTEXTOS,
    parameter int W       = escalonador_pkg::ID_W
) (
    input  logic [NUM_CTX-1:0] i_mapa,
    input  logic [W-1:0]       i_inicio,
    output logic [W-1:0]       o_id,
    output logic               o_achou
);
    always_comb begin
        int           v_base;
        int           v_pos;
        logic [W-1:0] v_cand;
        o_id    = '0;
        o_achou = 1'b0;
        v_pos   = 0;
        v_cand  = '0;
        // Positions 0..NUM_CTX-2 map to IDs 1..NUM_CTX-1; walk backwards so the
        // earliest position in scan order is the last (winning) assignment.
        v_base  = (int'(i_inicio) == 0) ? 0 : (int'(i_inicio) % (NUM_CTX - 1));
        for (int k = NUM_CTX - 2; k >= 0; k--) begin
            v_pos  = (v_base + k) % (NUM_CTX - 1);
            v_cand = W'(v_pos + 1);
            if (i_mapa[v_cand]) begin
                o_id    = v_cand;
                o_achou = 1'b1;
            end
        end
    end
endmodule

// File: rtl/escalonador.sv
// Round-robin context scheduler: keeps the ready bitmap, picks the next context
// on a timer request and hands it to the consumer through a valid/ack handshake.
module escalonador
    import escalonador_pkg::*;
#(
    parameter int NUM_CONTEXTOS = escalonador_pkg::NUM_CONTEXTOS,
    parameter int ID_W          = escalonador_pkg::ID_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ativar,
    input  logic [ID_W-1:0]          ativar_id,
    input  logic                     encerrar,
    input  logic [ID_W-1:0]          encerrar_id,
    input  logic                     pedido_troca,
    input  logic                     prox_ack,
    output logic [31:0]              prox_contexto,
    output logic                     prox_valido,
    output logic [NUM_CONTEXTOS-1:0] prontos,
    output logic [15:0]              num_trocas,
    output logic                     pedido_perdido
);
    estado_t                  r_estado;
    estado_t                  w_prox_estado;
    logic [NUM_CONTEXTOS-1:0] r_prontos;
    logic [ID_W-1:0]          r_ultimo;
    logic [ID_W-1:0]          r_escolhido;
    logic [ID_W-1:0]          w_id_rr;
    logic                     w_achou;
    logic                     w_ativa_ok;
    logic                     w_encerra_ok;
    logic                     w_entregue;
    logic                     w_cancela;
    logic [15:0]              r_num_trocas;
    logic                     r_perdido;

    assign w_ativa_ok   = ativar && (ativar_id != SO_ID) && (int'(ativar_id) < NUM_CONTEXTOS);
    assign w_encerra_ok = encerrar && (int'(encerrar_id) < NUM_CONTEXTOS);
    assign w_entregue   = (r_estado == ENTREGA) && prox_ack;
    // Killing the context we are offering forces a fresh pick; SO is never killed.
    assign w_cancela    = (r_estado == ENTREGA) && !prox_ack && encerrar
                          && (encerrar_id == r_escolhido) && (r_escolhido != SO_ID);

    seletor_rr #(
        .NUM_CTX (NUM_CONTEXTOS),
        .W       (ID_W)
    ) u_seletor (
        .i_mapa   (r_prontos),
        .i_inicio (r_ultimo),
        .o_id     (w_id_rr),
        .o_achou  (w_achou)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prontos <= '0;
        end else begin
            if (w_ativa_ok)   r_prontos[ativar_id]   <= 1'b1;
            if (w_encerra_ok) r_prontos[encerrar_id] <= 1'b0;
            r_prontos[0] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_estado <= OCIOSO;
        else        r_estado <= w_prox_estado;
    end

    always_comb begin
        w_prox_estado = r_estado;
        case (r_estado)
            OCIOSO:  if (pedido_troca) w_prox_estado = BUSCA;
            BUSCA:   w_prox_estado = ENTREGA;
            ENTREGA: begin
                if (prox_ack)       w_prox_estado = OCIOSO;
                else if (w_cancela) w_prox_estado = BUSCA;
            end
            default: w_prox_estado = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_escolhido  <= SO_ID;
            r_ultimo     <= SO_ID;
            r_num_trocas <= '0;
            r_perdido    <= 1'b0;
        end else begin
            if (r_estado == BUSCA) r_escolhido <= w_achou ? w_id_rr : SO_ID;
            if (w_entregue) begin
                r_ultimo <= r_escolhido;
                if (r_num_trocas != 16'hFFFF) r_num_trocas <= r_num_trocas + 16'd1;
            end
            if (pedido_troca && (r_estado != OCIOSO)) r_perdido <= 1'b1;
        end
    end

    assign prox_contexto  = {{(32-ID_W){1'b0}}, r_escolhido};
    assign prox_valido    = (r_estado == ENTREGA);
    assign prontos        = r_prontos;
    assign num_trocas     = r_num_trocas;
    assign pedido_perdido = r_perdido;
endmodule

// File: tb/tb_escalonador.sv
// Self-checking bench for escalonador: bitmap vector table, directed handshake
// sequences and a randomized run against a round-robin reference model.
module tb_escalonador;
    localparam int NC = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ativar = 1'b0;
    logic [IW-1:0] ativar_id = '0;
    logic          encerrar = 1'b0;
    logic [IW-1:0] encerrar_id = '0;
    logic          pedido_troca = 1'b0;
    logic          prox_ack = 1'b0;
    logic [31:0]   prox_contexto;
    logic          prox_valido;
    logic [NC-1:0] prontos;
    logic [15:0]   num_trocas;
    logic          pedido_perdido;

    int n_total = 0;
    int n_pass  = 0;

    escalonador dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ativar         (ativar),
        .ativar_id      (ativar_id),
        .encerrar       (encerrar),
        .encerrar_id    (encerrar_id),
        .pedido_troca   (pedido_troca),
        .prox_ack       (prox_ack),
        .prox_contexto  (prox_contexto),
        .prox_valido    (prox_valido),
        .prontos        (prontos),
        .num_trocas     (num_trocas),
        .pedido_perdido (pedido_perdido)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          a;
        logic [IW-1:0] aid;
        logic          e;
        logic [IW-1:0] eid;
        logic [NC-1:0] exp_prontos;
    } vec_t;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nome, got, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ativar = 1'b0; encerrar = 1'b0; pedido_troca = 1'b0; prox_ack = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic ativa(input logic [IW-1:0] id);
        ativar = 1'b1; ativar_id = id;
        tick();
        ativar = 1'b0;
    endtask

    // Request a switch and step to the ENTREGA cycle, checking the 2-cycle latency.
    task automatic troca(output logic [31:0] ctx);
        pedido_troca = 1'b1;
        tick();
        pedido_troca = 1'b0;
        check("lat_busca_valido", 32'(prox_valido), 32'd0);
        tick();
        check("lat_entrega_valido", 32'(prox_valido), 32'd1);
        ctx = prox_contexto;
    endtask

    task automatic ack();
        prox_ack = 1'b1;
        tick();
        prox_ack = 1'b0;
        check("ack_valido_cai", 32'(prox_valido), 32'd0);
    endtask

    // Scan order straight from the rule: ultimo+1 .. NC-1, then 1 .. ultimo.
    function automatic int model_pick(input logic [NC-1:0] rdy, input int ult);
        for (int k = 1; k < NC; k++) begin
            int id;
            id = ((ult + k - 1) % (NC - 1)) + 1;
            if (((rdy >> id) & 8'd1) != 8'd0) return id;
        end
        return 0;
    endfunction

    initial begin
        vec_t          vt[9];
        logic [31:0]   ctx;
        logic [NC-1:0] m_rdy;
        int            m_ult;
        int            m_cnt;
        int            exp_id;
        int            ncic;

        vt[0] = '{1'b1, 3'd3, 1'b0, 3'd0, 8'h08};
        vt[1] = '{1'b1, 3'd0, 1'b0, 3'd0, 8'h08};
        vt[2] = '{1'b1, 3'd3, 1'b1, 3'd3, 8'h00};
        vt[3] = '{1'b1, 3'd7, 1'b0, 3'd0, 8'h80};
        vt[4] = '{1'b1, 3'd1, 1'b1, 3'd7, 8'h02};
        vt[5] = '{1'b0, 3'd0, 1'b1, 3'd1, 8'h00};
        vt[6] = '{1'b1, 3'd0, 1'b0, 3'd0, 8'h00};
        vt[7] = '{1'b1, 3'd5, 1'b1, 3'd2, 8'h20};
        vt[8] = '{1'b0, 3'd0, 1'b1, 3'd5, 8'h00};

        tick();
        check("rst_prontos", 32'(prontos), 32'd0);
        check("rst_valido", 32'(prox_valido), 32'd0);
        check("rst_contexto", prox_contexto, 32'd0);
        check("rst_trocas", 32'(num_trocas), 32'd0);
        check("rst_perdido", 32'(pedido_perdido), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            ativar = vt[i].a; ativar_id = vt[i].aid;
            encerrar = vt[i].e; encerrar_id = vt[i].eid;
            tick();
            check($sformatf("vec%0d_prontos", i), 32'(prontos), 32'(vt[i].exp_prontos));
        end
        ativar = 1'b0; encerrar = 1'b0;

        prox_ack = 1'b1; tick(); prox_ack = 1'b0; tick();
        check("ack_ocioso_trocas", 32'(num_trocas), 32'd0);
        check("ack_ocioso_valido", 32'(prox_valido), 32'd0);

        do_reset();
        ativa(3'd2); ativa(3'd5);
        troca(ctx); check("rr_primeiro", ctx, 32'd2); ack();
        troca(ctx); check("rr_segundo", ctx, 32'd5); ack();
        troca(ctx); check("rr_wrap", ctx, 32'd2); ack();
        check("rr_trocas", 32'(num_trocas), 32'd3);

        do_reset();
        troca(ctx); check("vazio_contexto", ctx, 32'd0); ack();
        check("vazio_trocas", 32'(num_trocas), 32'd1);

        do_reset();
        ativa(3'd4);
        troca(ctx); check("cancela_latched", ctx, 32'd4);
        encerrar = 1'b1; encerrar_id = 3'd4;
        tick();
        encerrar = 1'b0;
        check("cancela_valido_cai", 32'(prox_valido), 32'd0);
        check("cancela_prontos", 32'(prontos), 32'd0);
        tick();
        check("cancela_revalida", 32'(prox_valido), 32'd1);
        check("cancela_rescan", prox_contexto, 32'd0);
        ack();

        do_reset();
        ativa(3'd2);
        troca(ctx); check("perdido_ctx", ctx, 32'd2);
        pedido_troca = 1'b1; tick(); pedido_troca = 1'b0;
        check("perdido_flag", 32'(pedido_perdido), 32'd1);
        check("perdido_segura_valido", 32'(prox_valido), 32'd1);
        ack();
        tick(); tick(); tick();
        check("perdido_sem_extra_valido", 32'(prox_valido), 32'd0);
        check("perdido_sem_extra_trocas", 32'(num_trocas), 32'd1);
        check("perdido_sticky", 32'(pedido_perdido), 32'd1);
        troca(ctx);
        rst_n = 1'b0;
        #1;
        check("rst_meio_valido", 32'(prox_valido), 32'd0);
        check("rst_meio_contexto", prox_contexto, 32'd0);
        check("rst_meio_prontos", 32'(prontos), 32'd0);
        check("rst_meio_trocas", 32'(num_trocas), 32'd0);
        check("rst_meio_perdido", 32'(pedido_perdido), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("pos_rst_valido", 32'(prox_valido), 32'd0);
        troca(ctx); check("pos_rst_ctx", ctx, 32'd0); ack();
        check("pos_rst_trocas", 32'(num_trocas), 32'd1);

        do_reset();
        ativa(3'd6);
        force dut.r_num_trocas = 16'hFFFE;
        tick();
        release dut.r_num_trocas;
        tick();
        check("sat_forcado", 32'(num_trocas), 32'h0000FFFE);
        for (int h = 0; h < 3; h++) begin
            troca(ctx); ack();
            check($sformatf("sat_h%0d", h), 32'(num_trocas), 32'h0000FFFF);
        end

        do_reset();
        m_rdy = '0; m_ult = 0; m_cnt = 0;
        for (int it = 0; it < 40; it++) begin
            ncic = $urandom_range(1, 4);
            for (int c = 0; c < ncic; c++) begin
                ativar      = 1'($urandom_range(0, 1));
                ativar_id   = IW'($urandom_range(0, NC - 1));
                encerrar    = 1'($urandom_range(0, 3) == 0);
                encerrar_id = IW'($urandom_range(0, NC - 1));
                tick();
                if (ativar && ativar_id != 3'd0) m_rdy[ativar_id] = 1'b1;
                if (encerrar) m_rdy[encerrar_id] = 1'b0;
                check("rand_prontos", 32'(prontos), 32'(m_rdy));
            end
            ativar = 1'b0; encerrar = 1'b0;
            exp_id = model_pick(m_rdy, m_ult);
            troca(ctx);
            check("rand_ctx", ctx, 32'(exp_id));
            ack();
            m_ult = exp_id;
            m_cnt++;
            check("rand_trocas", 32'(num_trocas), 32'(m_cnt));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
